// File: rtl/mem_stage.sv
// Memory pipeline stage: forwards ALU results and runs one load/store at a
// time on a simple req/ack bus with a bounded wait and an error pulse.
//
//   state | meaning
//   IDLE  | accepting inputs; ALU results and misalignment errors resolve here
//   REQ   | bus request held until ack or the wait counter reaches TIMEOUT
//   RESP  | single writeback cycle for the completed access
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [63:0] i_data,
    input  logic [63:0] i_addr,
    input  logic [4:0]  i_rd,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic [31:0] wb_pc,
    output logic        mem_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, state_nxt;
    logic [63:0] addr_q, data_q;
    logic [1:0]  size_q;
    logic        uns_q, load_q, store_q, flush_q;
    logic [4:0]  rd_q;
    logic [31:0] pc_q;
    logic [7:0]  wait_cnt;
    logic        alu_v_q, err_q;
    logic [63:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_pc_q;

    logic        accept, is_mem, misaligned, wait_last;
    logic [63:0] line_sh, load_ext;
    logic [7:0]  strb_base;

    assign accept    = (state == IDLE) && i_valid && !i_flush;
    assign is_mem    = i_is_load || i_is_store;
    assign wait_last = (wait_cnt + 8'd1) == TIMEOUT_CNT;

    always_comb begin
        misaligned = 1'b0;
        case (i_size)
            2'd1:    misaligned = i_addr[0];
            2'd2:    misaligned = |i_addr[1:0];
            2'd3:    misaligned = |i_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Load extraction works on the live bus line so it can be registered at ack.
    assign line_sh = mem_rdata >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_ext = line_sh;
        case (size_q)
            2'd0: load_ext = uns_q ? {56'd0, line_sh[7:0]}  : {{56{line_sh[7]}},  line_sh[7:0]};
            2'd1: load_ext = uns_q ? {48'd0, line_sh[15:0]} : {{48{line_sh[15]}}, line_sh[15:0]};
            2'd2: load_ext = uns_q ? {32'd0, line_sh[31:0]} : {{32{line_sh[31]}}, line_sh[31:0]};
            default: load_ext = line_sh;
        endcase
    end

    always_comb begin
        strb_base = 8'hFF;
        case (size_q)
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_mem && !misaligned) state_nxt = REQ;
            REQ: begin
                if (mem_ack)        state_nxt = RESP;
                else if (wait_last) state_nxt = IDLE;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            data_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            flush_q   <= 1'b0;
            rd_q      <= '0;
            pc_q      <= '0;
            wait_cnt  <= '0;
            alu_v_q   <= 1'b0;
            err_q     <= 1'b0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_pc_q   <= '0;
        end else begin
            alu_v_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            alu_v_q   <= 1'b1;
                            wb_rd_q   <= i_rd;
                            wb_data_q <= i_data;
                            wb_pc_q   <= i_pc;
                        end else if (misaligned) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q   <= i_addr;
                            data_q   <= i_data;
                            size_q   <= i_size;
                            uns_q    <= i_unsigned;
                            load_q   <= i_is_load;
                            store_q  <= i_is_store;
                            rd_q     <= i_rd;
                            pc_q     <= i_pc;
                            wait_cnt <= '0;
                            flush_q  <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    // A flush only marks the access; the bus handshake still completes.
                    if (i_flush) flush_q <= 1'b1;
                    if (mem_ack) begin
                        wb_rd_q   <= load_q ? rd_q : 5'd0;
                        wb_data_q <= load_q ? load_ext : 64'd0;
                        wb_pc_q   <= pc_q;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_last) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall     = (state != IDLE);
    assign mem_req   = (state == REQ);
    assign mem_we    = mem_req && store_q;
    assign mem_addr  = {addr_q[63:3], 3'b000};
    assign mem_wstrb = mem_req ? (strb_base << addr_q[2:0]) : 8'h00;
    assign mem_wdata = data_q << {addr_q[2:0], 3'b000};
    assign wb_valid  = alu_v_q || ((state == RESP) && !flush_q && !i_flush);
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign wb_pc     = wb_pc_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with a byte-level reference model of loads,
// stores, alignment, timeout and flush behaviour.
module tb_mem_stage;
    localparam int TMO = 4;

    logic        clk, reset;
    logic        i_valid, i_is_load, i_is_store, i_unsigned, i_flush;
    logic [63:0] i_data, i_addr;
    logic [4:0]  i_rd;
    logic [1:0]  i_size;
    logic [31:0] i_pc;
    logic        stall, mem_req, mem_we, mem_ack, mem_err, wb_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata, wb_data;
    logic [7:0]  mem_wstrb;
    logic [4:0]  wb_rd;
    logic [31:0] wb_pc;

    int n_checks = 0;
    int n_fails  = 0;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_data(i_data), .i_addr(i_addr), .i_rd(i_rd),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_pc(i_pc), .i_flush(i_flush),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_pc(wb_pc), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] line, input int o,
                                               input int size, input logic uns);
        int n;
        logic [63:0] v;
        n = 1 << size;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = line[8*(o+k) +: 8];
        if (!uns && n < 8 && v[8*n-1])
            for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] model_strb(input int o, input int size);
        logic [7:0] s;
        s = '0;
        for (int k = 0; k < (1 << size); k++) s[o+k] = 1'b1;
        return s;
    endfunction

    task automatic clear_inputs();
        i_valid = 0; i_is_load = 0; i_is_store = 0; i_flush = 0; mem_ack = 0;
    endtask

    // kind: 0 alu, 1 load, 2 store. ack_at: REQ cycle index of ack, -1 = never.
    // flush_mode: 0 none, 1 flush in REQ, 2 flush in RESP, 3 flush with the input.
    task automatic run_op(input int kind, input int size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] data,
                          input logic [4:0] rd, input logic [31:0] pc,
                          input int ack_at, input int flush_mode,
                          input logic [63:0] rdata);
        int  o;
        bit  mis, acked;
        o = int'(addr[2:0]);
        mis = (kind != 0) && ((o % (1 << size)) != 0);
        @(negedge clk);
        check("idle_stall", stall, 0);
        check("idle_wb_valid", wb_valid, 0);
        check("idle_mem_req", mem_req, 0);
        i_valid = 1; i_data = data; i_addr = addr; i_rd = rd; i_pc = pc;
        i_size = 2'(size); i_unsigned = uns;
        i_is_load = (kind == 1); i_is_store = (kind == 2);
        i_flush = (flush_mode == 3);
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        mem_ack = 0;
        if (flush_mode == 3) begin
            check("iflush_wb_valid", wb_valid, 0);
            check("iflush_mem_req", mem_req, 0);
            check("iflush_stall", stall, 0);
            check("iflush_err", mem_err, 0);
            clear_inputs();
            return;
        end
        if (kind == 0) begin
            check("alu_wb_valid", wb_valid, 1);
            check("alu_wb_rd", wb_rd, rd);
            check("alu_wb_data", wb_data, data);
            check("alu_wb_pc", wb_pc, pc);
            check("alu_mem_req", mem_req, 0);
            check("alu_stall", stall, 0);
            clear_inputs();
            return;
        end
        if (mis) begin
            check("mis_err", mem_err, 1);
            check("mis_wb_valid", wb_valid, 0);
            check("mis_mem_req", mem_req, 0);
            check("mis_stall", stall, 0);
            clear_inputs();
            return;
        end
        acked = 0;
        for (int c = 0; c < TMO; c++) begin
            check("req_mem_req", mem_req, 1);
            check("req_stall", stall, 1);
            check("req_wb_valid", wb_valid, 0);
            check("req_err", mem_err, 0);
            check("req_addr", mem_addr, addr & ~64'h7);
            check("req_we", mem_we, kind == 2);
            if (kind == 2) begin
                check("req_wstrb", mem_wstrb, model_strb(o, size));
                check("req_wdata", mem_wdata, data << (8 * o));
            end
            i_flush = (flush_mode == 1) && (c == 0);
            mem_ack = (c == ack_at);
            mem_rdata = (c == ack_at) ? rdata : {$urandom, $urandom};
            @(negedge clk);
            mem_ack = 0;
            i_flush = 0;
            mem_rdata = {$urandom, $urandom};
            if (c == ack_at) begin
                acked = 1;
                break;
            end
        end
        if (!acked) begin
            check("tmo_err", mem_err, 1);
            check("tmo_mem_req", mem_req, 0);
            check("tmo_stall", stall, 0);
            check("tmo_wb_valid", wb_valid, 0);
            clear_inputs();
            return;
        end
        check("resp_mem_req", mem_req, 0);
        check("resp_stall", stall, 1);
        check("resp_err", mem_err, 0);
        if (flush_mode == 2) begin
            i_flush = 1;
            #1;
        end
        check("resp_wb_valid", wb_valid, flush_mode == 0);
        if (flush_mode == 0) begin
            check("resp_wb_rd", wb_rd, (kind == 1) ? rd : 5'd0);
            check("resp_wb_pc", wb_pc, pc);
            if (kind == 1) check("resp_wb_data", wb_data, model_load(rdata, o, size, uns));
        end
        @(negedge clk);
        i_flush = 0;
        check("post_stall", stall, 0);
        check("post_wb_valid", wb_valid, 0);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        i_data = '0; i_addr = '0; i_rd = '0; i_pc = '0; i_size = '0; i_unsigned = 0;
        mem_rdata = '0;
        reset = 0;
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_pc", wb_pc, 0);
        check("rst_err", mem_err, 0);
        @(negedge clk);
        reset = 1;

        run_op(0, 3, 0, 64'h0, 64'h1234, 5'd5, 32'h100, 0, 0, 64'h0);
        run_op(1, 0, 0, 64'h1003, 64'h0, 5'd7, 32'h104, 2, 0, 64'h0000_0000_8000_0000);
        run_op(1, 0, 1, 64'h1003, 64'h0, 5'd7, 32'h108, 2, 0, 64'h0000_0000_8000_0000);
        run_op(2, 1, 0, 64'h2006, 64'hABCD, 5'd9, 32'h10C, 1, 0, 64'h0);
        run_op(1, 2, 0, 64'h3002, 64'h0, 5'd3, 32'h110, 0, 0, 64'h0);
        run_op(1, 3, 0, 64'h4000, 64'h0, 5'd4, 32'h114, -1, 0, 64'h0);
        run_op(1, 3, 0, 64'h4008, 64'h0, 5'd4, 32'h118, TMO - 1, 0, 64'h1122_3344_5566_7788);
        run_op(1, 2, 1, 64'h5004, 64'h0, 5'd6, 32'h11C, 2, 1, 64'hDEAD_BEEF_0000_0000);
        run_op(2, 3, 0, 64'h6000, 64'h55, 5'd0, 32'h120, 0, 2, 64'h0);
        run_op(0, 0, 0, 64'h0, 64'h77, 5'd8, 32'h124, 0, 3, 64'h0);

        // Reset mid-request: bus request must drop at once and a stale ack is ignored.
        @(negedge clk);
        i_valid = 1; i_is_load = 1; i_addr = 64'h40; i_size = 2'd3; i_rd = 5'd2;
        @(negedge clk);
        check("rreq_mem_req", mem_req, 1);
        reset = 0;
        #1;
        check("rreq_async_req", mem_req, 0);
        check("rreq_async_stall", stall, 0);
        check("rreq_async_wstrb", mem_wstrb, 0);
        clear_inputs();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        mem_ack = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_ack = 0;
        check("rreq_late_ack_wb", wb_valid, 0);
        check("rreq_late_ack_stall", stall, 0);
        check("rreq_late_ack_err", mem_err, 0);

        for (int t = 0; t < 80; t++) begin
            int kind, size, ack_at, fm, n;
            logic [63:0] addr;
            kind = $urandom_range(0, 2);
            size = $urandom_range(0, 3);
            n = 1 << size;
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr = addr & ~(64'(n) - 64'd1);
            ack_at = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, TMO - 1);
            fm = $urandom_range(0, 9);
            if (fm > 3) fm = 0;
            run_op(kind, size, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom},
                   5'($urandom), $urandom, ack_at, fm, {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
